// File: rtl/rt_pkg.sv
// Shared types and constants for the ray tracer front end.
// Record word layout, FIFO geometry and the sequencer state encoding.
package rt_pkg;

    localparam int WORD_BITS      = 32;
    localparam int RAY_WORDS      = 6;
    localparam int TRI_WORDS      = 18;
    localparam int RAY_FIFO_DEPTH = 16;

    // Word positions inside an 18-word triangle record
    localparam int V0_X  = 0;
    localparam int V0_Y  = 1;
    localparam int V0_Z  = 2;
    localparam int V1_X  = 3;
    localparam int V1_Y  = 4;
    localparam int V1_Z  = 5;
    localparam int V2_X  = 6;
    localparam int V2_Y  = 7;
    localparam int V2_Z  = 8;
    localparam int NRM_X = 9;
    localparam int NRM_Y = 10;
    localparam int NRM_Z = 11;

    typedef logic [RAY_WORDS-1:0][WORD_BITS-1:0] ray_t;
    typedef logic [TRI_WORDS-1:0][WORD_BITS-1:0] tri_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

endpackage

// File: rtl/ray_fifo.sv
// Circular-buffer FIFO with a registered occupancy count.
// Writes while full and reads while empty are ignored; full/empty come from the count.
module ray_fifo #(
    parameter int WIDTH = 192,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= next_ptr(wr_ptr);
            if (do_rd) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
        end
    end

    // Storage needs no reset: stale entries are unreachable once count is cleared
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/raytracer_top.sv
// Ray tracer front end: queues host rays and, per popped ray, sweeps every
// triangle record of the ROM onto instruction_read, one record per cycle.
module raytracer_top
    import rt_pkg::*;
#(
    parameter int D_BITS = 32,
    parameter int M_BITS = 12,
    parameter int Q_BITS = 10
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     in_wr_en,
    input  logic [RAY_WORDS-1:0][D_BITS-1:0]         ray_in,
    output logic                                     in_full,
    output logic signed [TRI_WORDS-1:0][D_BITS-1:0]  instruction_read
);

    typedef logic [TRI_WORDS-1:0][D_BITS-1:0] rec_t;

    seq_state_e                      state;
    seq_state_e                      state_next;
    logic [M_BITS-1:0]               addr;
    logic                            fifo_empty;
    logic                            pop;
    logic                            rd_en;
    logic [RAY_WORDS-1:0][D_BITS-1:0] fifo_head;
    // Current ray, consumed by the downstream intersection stage
    logic [RAY_WORDS-1:0][D_BITS-1:0] ray_reg_unused;

    // Default ROM contents: word k of record a is (a*18 + k) in Q format
    function automatic rec_t rom_record(input logic [M_BITS-1:0] a);
        rec_t r;
        for (int k = 0; k < TRI_WORDS; k++) begin
            r[k] = (D_BITS'(a) * D_BITS'(TRI_WORDS) + D_BITS'(k)) << Q_BITS;
        end
        return r;
    endfunction

    ray_fifo #(
        .WIDTH (RAY_WORDS * D_BITS),
        .DEPTH (RAY_FIFO_DEPTH)
    ) u_ray_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (in_wr_en),
        .wr_data (ray_in),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .full    (in_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        rd_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                rd_en = 1'b1;
                if (addr == {M_BITS{1'b1}}) state_next = ST_DRAIN;
            end
            ST_DRAIN: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Datapath: address counter, ray latch and the ROM output register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr             <= '0;
            ray_reg_unused   <= '0;
            instruction_read <= '0;
        end else begin
            if (pop) begin
                addr           <= '0;
                ray_reg_unused <= fifo_head;
            end else if (rd_en) begin
                addr <= addr + M_BITS'(1);
            end
            if (rd_en) instruction_read <= rom_record(addr);
        end
    end

endmodule

// File: tb/tb_raytracer_top.sv
// Bench for raytracer_top: two instances (3-bit and 12-bit address), a
// time-based reference model of queueing and sweeps, and per-cycle checks.
module tb_raytracer_top;
    import rt_pkg::*;

    logic       clock = 1'b0;
    logic       reset_s = 1'b0;
    logic       reset_b = 1'b0;
    logic       wr_en_s = 1'b0;
    logic       wr_en_b = 1'b0;
    ray_t       ray_drv = '0;
    logic       full_s, full_b;
    tri_t       rec_s, rec_b;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;

    // Reference model state
    bit         sel_big = 1'b0;
    int         edge_n = 0;
    ray_t       mq[$];
    bit         sweeping = 1'b0;
    int         pop_edge = 0;
    int         next_pop_ok = 0;
    tri_t       exp_rec = '0;
    ray_t       exp_ray = '0;

    always #5 clock = ~clock;

    raytracer_top #(.D_BITS(32), .M_BITS(3), .Q_BITS(10)) dut_s (
        .clock            (clock),
        .reset            (reset_s),
        .in_wr_en         (wr_en_s),
        .ray_in           (ray_drv),
        .in_full          (full_s),
        .instruction_read (rec_s)
    );

    raytracer_top #(.D_BITS(32), .M_BITS(12), .Q_BITS(10)) dut_b (
        .clock            (clock),
        .reset            (reset_b),
        .in_wr_en         (wr_en_b),
        .ray_in           (ray_drv),
        .in_full          (full_b),
        .instruction_read (rec_b)
    );

    function automatic tri_t rec_of(input int a);
        tri_t r;
        for (int k = 0; k < TRI_WORDS; k++) r[k] = 32'((18 * a + k) * 1024);
        return r;
    endfunction

    function automatic ray_t mk_ray(input int v);
        ray_t r;
        for (int k = 0; k < RAY_WORDS; k++) r[k] = 32'(v);
        return r;
    endfunction

    function automatic ray_t rand_ray();
        ray_t r;
        for (int k = 0; k < RAY_WORDS; k++) r[k] = $urandom;
        return r;
    endfunction

    task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        sweeping    = 1'b0;
        next_pop_ok = 0;
        exp_rec     = '0;
        exp_ray     = '0;
    endtask

    // One rising edge: a ray leaves the queue when the previous sweep is done,
    // a write lands when the queue held fewer than 16 before the edge.
    task automatic model_edge(input bit wr, input ray_t r);
        int  nrec;
        int  sz;
        int  d;
        bit  do_pop;
        bit  do_push;
        nrec    = sel_big ? 4096 : 8;
        sz      = mq.size();
        do_pop  = (edge_n >= next_pop_ok) && (sz > 0);
        do_push = wr && (sz < RAY_FIFO_DEPTH);
        if (sweeping) begin
            d = edge_n - pop_edge;
            if (d >= 1 && d <= nrec) exp_rec = rec_of(d - 1);
        end
        if (do_pop) begin
            exp_ray     = mq.pop_front();
            pop_edge    = edge_n;
            sweeping    = 1'b1;
            next_pop_ok = edge_n + nrec + 2;
        end
        if (do_push) mq.push_back(r);
    endtask

    task automatic check_outputs(input string tag);
        logic f;
        tri_t rc;
        ray_t ry;
        f  = sel_big ? full_b : full_s;
        rc = sel_big ? rec_b : rec_s;
        ry = sel_big ? dut_b.ray_reg_unused : dut_s.ray_reg_unused;
        check({tag, "_full"}, 576'(f), 576'(mq.size() == RAY_FIFO_DEPTH));
        check({tag, "_rec"}, 576'(rc), 576'(exp_rec));
        check({tag, "_ray"}, 576'(ry), 576'(exp_ray));
    endtask

    // Entered and left 1 time unit after a rising edge
    task automatic cycle(input string tag, input bit wr, input ray_t r);
        bit rst_now;
        wr_en_s = wr && !sel_big;
        wr_en_b = wr && sel_big;
        ray_drv = r;
        @(posedge clock);
        edge_n++;
        rst_now = sel_big ? reset_b : reset_s;
        if (rst_now) model_edge(wr, r);
        else         model_clear();
        #1;
        wr_en_s = 1'b0;
        wr_en_b = 1'b0;
        check_outputs(tag);
    endtask

    task automatic do_reset(input bit big);
        reset_s = 1'b0;
        reset_b = 1'b0;
        wr_en_s = 1'b0;
        wr_en_b = 1'b0;
        sel_big = big;
        model_clear();
        repeat (2) @(posedge clock);
        edge_n += 2;
        #1;
        check("rst_full", 576'(big ? full_b : full_s), 576'(0));
        check("rst_rec", 576'(big ? rec_b : rec_s), 576'(0));
        if (big) reset_b = 1'b1;
        else     reset_s = 1'b1;
    endtask

    initial begin
        tri_t rc;

        // Single ray on the 8-record instance
        do_reset(1'b0);
        cycle("single_wr", 1'b1, mk_ray(1));
        for (int i = 0; i < 4; i++) cycle("single", 1'b0, '0);
        rc = rec_s;
        check("single_rec2_w0", 576'(rc[V0_X]), 576'(32'd36864));
        for (int i = 0; i < 10; i++) cycle("single", 1'b0, '0);
        rc = rec_s;
        check("single_hold_rec7_w17", 576'(rc[17]), 576'(32'd146432));
        check("single_hold_nrm_z", 576'(rc[NRM_Z]), 576'(32'((126 + 11) * 1024)));

        // Fill past capacity with incrementing rays, then drain in order
        for (int i = 1; i <= 19; i++) cycle("fill", 1'b1, mk_ray(i));
        check("fill_full_const", 576'(full_s), 576'(1));
        for (int i = 0; i < 200; i++) cycle("drain", 1'b0, '0);
        check("drain_empty_const", 576'(full_s), 576'(0));
        check("drain_last_ray", 576'(dut_s.ray_reg_unused), 576'(mk_ray(18)));

        // Random traffic with an asynchronous reset in the middle of a sweep
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                #2;
                reset_s = 1'b0;
                #1;
                model_clear();
                check("async_rst_full", 576'(full_s), 576'(0));
                check("async_rst_rec", 576'(rec_s), 576'(0));
                check("async_rst_ray", 576'(dut_s.ray_reg_unused), 576'(0));
                cycle("rst_hold", 1'b0, '0);
                reset_s = 1'b1;
            end
            cycle("rand", ($urandom_range(0, 2) == 0), rand_ray());
        end

        // Continuous stream on the 4096-record instance
        reset_s = 1'b0;
        do_reset(1'b1);
        for (int i = 1; i <= 10; i++) cycle("stream_wr", 1'b1, mk_ray(i));
        check("stream_ray1", 576'(dut_b.ray_reg_unused), 576'(mk_ray(1)));
        check("stream_not_full", 576'(full_b), 576'(0));
        for (int i = 0; i < 4200; i++) cycle("stream", 1'b0, '0);
        check("stream_ray2", 576'(dut_b.ray_reg_unused), 576'(mk_ray(2)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
